display_formatter: RTL and testbench

Sequential formatter that sits directly upstream of the per-digit seven-segment encoders. It accepts a signed two's-complement value over a valid/ready handshake and converts its magnitude to BCD using iterative double-dabble, one shift per cycle. It applies leading-zero blanking, places the minus sign, and flags overflow. The registered outputs feed each encoder's bin, neg and enable inputs directly.

---
 rtl/display_formatter.sv | 187 ++++++++++++++++++
 tb/tb_display_formatter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_formatter.sv
// Signed binary to seven-segment digit formatter: double-dabble BCD conversion,
// leading-zero blanking, minus-sign placement and overflow dashes.
module display_formatter #(
    parameter int WIDTH      = 10,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      blank,
    output logic [4*NUM_DIGITS-1:0]   bin_bus,
    output logic [NUM_DIGITS-1:0]     neg_bus,
    output logic [NUM_DIGITS-1:0]     en_bus,
    output logic                      out_valid,
    overflow
);

    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABS,
        ST_CONVERT,
        ST_FORMAT
    } state_t;

    state_t                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic [WIDTH-1:0]          data_q, data_d;
    logic [WIDTH-1:0]          mag_q, mag_d;
    logic [BCD_W-1:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   bin_q, bin_d;
    logic [NUM_DIGITS-1:0]     neg_q, neg_d;
    logic [NUM_DIGITS-1:0]     pat_q, pat_d;
    logic [NUM_DIGITS-1:0]     en_q, en_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overflow_q, overflow_d;

    logic [BCD_W-1:0]          bcd_adj;
    logic [2:0]                msd;
    logic                      fmt_ovf;
    logic [4*NUM_DIGITS-1:0]   fmt_bin;
    logic [NUM_DIGITS-1:0]     fmt_neg;
    logic [NUM_DIGITS-1:0]     fmt_en;

    // Handshake: a value transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so the source must hold in_valid/in_data until then.
    assign in_ready  = (state_q == ST_IDLE);
    assign bin_bus   = bin_q;
    assign neg_bus   = neg_q;
    assign en_bus    = en_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        msd = '0;
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if (bcd_q[4*j +: 4] != 4'd0) begin
                msd = 3'(j);
            end
        end

        fmt_ovf = 1'b0;
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if (j >= NUM_DIGITS && bcd_q[4*j +: 4] != 4'd0) begin
                fmt_ovf = 1'b1;
            end
        end
        // A negative value also needs a free position for its minus sign.
        if (sign_q && bcd_q[4*(NUM_DIGITS-1) +: 4] != 4'd0) begin
            fmt_ovf = 1'b1;
        end

        fmt_bin = '0;
        fmt_neg = '0;
        fmt_en  = '0;
        if (fmt_ovf) begin
            fmt_neg = '1;
            fmt_en  = '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i <= int'(msd)) begin
                    fmt_en[i]         = 1'b1;
                    fmt_bin[4*i +: 4] = bcd_q[4*i +: 4];
                end else if (sign_q && i == int'(msd) + 1) begin
                    fmt_en[i]  = 1'b1;
                    fmt_neg[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        data_d      = data_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        neg_d       = neg_q;
        pat_d       = pat_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    sign_d  = in_data[WIDTH-1];
                    state_d = ST_ABS;
                end
            end
            ST_ABS: begin
                // Unsigned view makes the most negative input map to 2^(WIDTH-1).
                mag_d   = sign_q ? (-data_q) : data_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                bin_d       = fmt_bin;
                neg_d       = fmt_neg;
                pat_d       = fmt_en;
                overflow_d  = fmt_ovf;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        en_d = pat_d & ~{NUM_DIGITS{blank}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            data_q      <= '0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            neg_q       <= '0;
            pat_q       <= NUM_DIGITS'(1);
            en_q        <= NUM_DIGITS'(1);
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            data_q      <= data_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            neg_q       <= neg_d;
            pat_q       <= pat_d;
            en_q        <= en_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_display_formatter.sv
// Bench for display_formatter: default (WIDTH=10) and WIDTH=14 instances, table
// vectors, randomized stream against an arithmetic reference model, corner sequences.
module tb_display_formatter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_blank = 1'b0, a_out_valid, a_overflow;
    logic [9:0]  a_in_data = '0;
    logic [15:0] a_bin_bus;
    logic [3:0]  a_neg_bus, a_en_bus;

    logic        b_in_valid = 1'b0, b_in_ready, b_blank = 1'b0, b_out_valid, b_overflow;
    logic [13:0] b_in_data = '0;
    logic [15:0] b_bin_bus;
    logic [3:0]  b_neg_bus, b_en_bus;

    display_formatter dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .blank(a_blank), .bin_bus(a_bin_bus),
        .neg_bus(a_neg_bus), .en_bus(a_en_bus), .out_valid(a_out_valid),
        .overflow(a_overflow)
    );

    display_formatter #(.WIDTH(14), .NUM_DIGITS(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .blank(b_blank), .bin_bus(b_bin_bus),
        .neg_bus(b_neg_bus), .en_bus(b_en_bus), .out_valid(b_out_valid),
        .overflow(b_overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected display for value v on four digits, packed {ovf, en, neg, bin}.
    function automatic logic [24:0] model(input int v);
        int mag;
        int dig[5];
        int k;
        logic ovf;
        logic [3:0] en, neg;
        logic [15:0] bin;
        mag = (v < 0) ? -v : v;
        k = 0;
        for (int j = 0; j < 5; j++) begin
            dig[j] = mag % 10;
            mag = mag / 10;
            if (dig[j] != 0) k = j;
        end
        ovf = (dig[4] != 0) || (v < 0 && dig[3] != 0);
        if (ovf) return {1'b1, 4'b1111, 4'b1111, 16'h0000};
        en = '0; neg = '0; bin = '0;
        for (int i = 0; i < 4; i++) begin
            if (i <= k) begin
                en[i] = 1'b1;
                bin[4*i +: 4] = 4'(dig[i]);
            end else if (v < 0 && i == k + 1) begin
                en[i] = 1'b1;
                neg[i] = 1'b1;
            end
        end
        return {1'b0, en, neg, bin};
    endfunction

    // Scoreboards: expected results queued at acceptance, popped at out_valid.
    logic [24:0] exp_q_a[$];
    logic [24:0] exp_q_b[$];
    int acc_q_a[$];
    int acc_q_b[$];
    int cyc_a = 0, cyc_b = 0;
    int last_acc_a = -1;
    bit stream_a = 1'b0;
    logic ov_prev_a = 1'b0, ov_prev_b = 1'b0;
    logic blank_prev_a = 1'b0, blank_prev_b = 1'b0;
    logic [24:0] e_a, e_b;
    int t_a, t_b;

    always @(negedge clk) begin
        cyc_a = cyc_a + 1;
        if (ov_prev_a) check("a_pulse_width", {31'b0, a_out_valid}, 0);
        if (a_out_valid) begin
            if (exp_q_a.size() == 0) check("a_spurious_valid", {31'b0, a_out_valid}, 0);
            else begin
                e_a = exp_q_a.pop_front();
                t_a = acc_q_a.pop_front();
                check("a_latency", cyc_a - t_a, 13);
                check("a_sb_bin", {16'b0, a_bin_bus}, {16'b0, e_a[15:0]});
                check("a_sb_neg", {28'b0, a_neg_bus}, {28'b0, e_a[19:16]});
                check("a_sb_en", {28'b0, a_en_bus}, {28'b0, e_a[23:20] & ~{4{blank_prev_a}}});
                check("a_sb_ovf", {31'b0, a_overflow}, {31'b0, e_a[24]});
            end
        end
        if (rst) begin
            exp_q_a.delete();
            acc_q_a.delete();
        end else if (a_in_valid && a_in_ready) begin
            if (stream_a && last_acc_a >= 0) check("a_accept_spacing", cyc_a - last_acc_a, 13);
            if (stream_a) last_acc_a = cyc_a;
            exp_q_a.push_back(model(int'($signed(a_in_data))));
            acc_q_a.push_back(cyc_a);
        end
        ov_prev_a = a_out_valid;
        blank_prev_a = a_blank;
    end

    always @(negedge clk) begin
        cyc_b = cyc_b + 1;
        if (ov_prev_b) check("b_pulse_width", {31'b0, b_out_valid}, 0);
        if (b_out_valid) begin
            if (exp_q_b.size() == 0) check("b_spurious_valid", {31'b0, b_out_valid}, 0);
            else begin
                e_b = exp_q_b.pop_front();
                t_b = acc_q_b.pop_front();
                check("b_latency", cyc_b - t_b, 17);
                check("b_sb_bin", {16'b0, b_bin_bus}, {16'b0, e_b[15:0]});
                check("b_sb_neg", {28'b0, b_neg_bus}, {28'b0, e_b[19:16]});
                check("b_sb_en", {28'b0, b_en_bus}, {28'b0, e_b[23:20] & ~{4{blank_prev_b}}});
                check("b_sb_ovf", {31'b0, b_overflow}, {31'b0, e_b[24]});
            end
        end
        if (rst) begin
            exp_q_b.delete();
            acc_q_b.delete();
        end else if (b_in_valid && b_in_ready) begin
            exp_q_b.push_back(model(int'($signed(b_in_data))));
            acc_q_b.push_back(cyc_b);
        end
        ov_prev_b = b_out_valid;
        blank_prev_b = b_blank;
    end

    // Driver: present one value, wait for acceptance, then for the result pulse.
    task automatic send(input bit sel, input int value, output logic [24:0] got, output bit ok);
        bit acc;
        @(posedge clk); #1;
        if (sel) begin b_in_valid = 1'b1; b_in_data = 14'(value); end
        else     begin a_in_valid = 1'b1; a_in_data = 10'(value); end
        acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc = sel ? b_in_ready : a_in_ready;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        ok = 1'b0;
        got = '0;
        if (acc) begin
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (sel ? b_out_valid : a_out_valid) begin
                    got = sel ? {b_overflow, b_en_bus, b_neg_bus, b_bin_bus}
                              : {a_overflow, a_en_bus, a_neg_bus, a_bin_bus};
                    ok = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        bit          sel;
        int          value;
        logic [15:0] bin;
        logic [3:0]  en;
        logic [3:0]  neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[17];
    logic [24:0] got;
    bit ok;
    int v;

    initial begin
        vecs[0]  = '{1'b0,    0, 16'h0000, 4'b0001, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0,  511, 16'h0511, 4'b0111, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0,   -7, 16'h0007, 4'b0011, 4'b0010, 1'b0};
        vecs[3]  = '{1'b0, -512, 16'h0512, 4'b1111, 4'b1000, 1'b0};
        vecs[4]  = '{1'b0,    1, 16'h0001, 4'b0001, 4'b0000, 1'b0};
        vecs[5]  = '{1'b0,   -1, 16'h0001, 4'b0011, 4'b0010, 1'b0};
        vecs[6]  = '{1'b0,  100, 16'h0100, 4'b0111, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0,  -99, 16'h0099, 4'b0111, 4'b0100, 1'b0};
        vecs[8]  = '{1'b0,   10, 16'h0010, 4'b0011, 4'b0000, 1'b0};
        vecs[9]  = '{1'b0,    9, 16'h0009, 4'b0001, 4'b0000, 1'b0};
        vecs[10] = '{1'b1, 8191, 16'h8191, 4'b1111, 4'b0000, 1'b0};
        vecs[11] = '{1'b1,-1000, 16'h0000, 4'b1111, 4'b1111, 1'b1};
        vecs[12] = '{1'b1, -999, 16'h0999, 4'b1111, 4'b1000, 1'b0};
        vecs[13] = '{1'b1,-8192, 16'h0000, 4'b1111, 4'b1111, 1'b1};
        vecs[14] = '{1'b1,    0, 16'h0000, 4'b0001, 4'b0000, 1'b0};
        vecs[15] = '{1'b1,   -1, 16'h0001, 4'b0011, 4'b0010, 1'b0};
        vecs[16] = '{1'b1, 1234, 16'h1234, 4'b1111, 4'b0000, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_a_bin", {16'b0, a_bin_bus}, 0);
        check("rst_a_en", {28'b0, a_en_bus}, 1);
        check("rst_a_neg", {28'b0, a_neg_bus}, 0);
        check("rst_a_ovf", {31'b0, a_overflow}, 0);
        check("rst_a_out_valid", {31'b0, a_out_valid}, 0);
        check("rst_a_in_ready", {31'b0, a_in_ready}, 1);
        check("rst_b_en", {28'b0, b_en_bus}, 1);
        check("rst_b_in_ready", {31'b0, b_in_ready}, 1);

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].sel, vecs[i].value, got, ok);
            check($sformatf("vec%0d_done", i), {31'b0, ok}, 1);
            check($sformatf("vec%0d_bin", i), {16'b0, got[15:0]}, {16'b0, vecs[i].bin});
            check($sformatf("vec%0d_neg", i), {28'b0, got[19:16]}, {28'b0, vecs[i].neg});
            check($sformatf("vec%0d_en", i), {28'b0, got[23:20]}, {28'b0, vecs[i].en});
            check($sformatf("vec%0d_ovf", i), {31'b0, got[24]}, {31'b0, vecs[i].ovf});
        end

        // in_valid held high with data changing every cycle, busy or not.
        @(posedge clk); #1;
        last_acc_a = -1;
        stream_a = 1'b1;
        a_in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a_in_data = 10'($urandom);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        stream_a = 1'b0;
        for (int i = 0; i < 40 && exp_q_a.size() != 0; i++) @(negedge clk);
        check("stream_drained", exp_q_a.size(), 0);

        // Reset in the middle of a conversion.
        send(1'b0, 123, got, ok);
        check("pre_rst_123", {7'b0, got}, {7'b0, 1'b0, 4'b0111, 4'b0000, 16'h0123});
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_data = 10'd300;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_bin", {16'b0, a_bin_bus}, 0);
        check("midrst_en", {28'b0, a_en_bus}, 1);
        check("midrst_neg", {28'b0, a_neg_bus}, 0);
        check("midrst_ovf", {31'b0, a_overflow}, 0);
        check("midrst_out_valid", {31'b0, a_out_valid}, 0);
        check("midrst_in_ready", {31'b0, a_in_ready}, 1);
        send(1'b0, 42, got, ok);
        check("post_rst_42", {7'b0, got}, {7'b0, 1'b0, 4'b0011, 4'b0000, 16'h0042});

        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 1023)) - 512;
            send(1'b0, v, got, ok);
            check("rand_a_done", {31'b0, ok}, 1);
            v = int'($urandom_range(0, 16383)) - 8192;
            send(1'b1, v, got, ok);
            check("rand_b_done", {31'b0, ok}, 1);
        end

        // blank takes effect one cycle later and leaves everything else alone.
        send(1'b1, -1000, got, ok);
        @(posedge clk); #1 b_blank = 1'b1;
        @(negedge clk);
        check("blank_delay_en", {28'b0, b_en_bus}, 4'b1111);
        @(negedge clk);
        check("blank_en", {28'b0, b_en_bus}, 0);
        check("blank_neg", {28'b0, b_neg_bus}, 4'b1111);
        check("blank_bin", {16'b0, b_bin_bus}, 0);
        check("blank_ovf", {31'b0, b_overflow}, 1);
        @(posedge clk); #1 b_blank = 1'b0;
        @(negedge clk);
        check("unblank_delay_en", {28'b0, b_en_bus}, 0);
        @(negedge clk);
        check("unblank_en", {28'b0, b_en_bus}, 4'b1111);

        // A conversion finishing while blanked stores its pattern for later.
        @(posedge clk); #1 b_blank = 1'b1;
        send(1'b1, 5, got, ok);
        check("blanked_conv", {7'b0, got}, {7'b0, 1'b0, 4'b0000, 4'b0000, 16'h0005});
        @(posedge clk); #1 b_blank = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("blanked_restore_en", {28'b0, b_en_bus}, 4'b0001);

        for (int i = 0; i < 50 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) @(negedge clk);
        check("final_drain_a", exp_q_a.size(), 0);
        check("final_drain_b", exp_q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
